// File: rtl/instr_fetch_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_if
//
// Purpose: bundles the fetch-stage bus of instr_fetch: the pipeline control
// inputs (stall, redirect), the instruction ROM address/data pair and the
// registered fetch result handed to decode.
//
// Signals:
//   stall           : downstream cannot accept; fetch holds everything
//   redirect_valid  : taken branch/jump resolved in decode
//   redirect_target : byte address of the branch/jump destination
//   rom_addr        : byte address driven to the instruction ROM
//   rom_data        : instruction word returned combinationally for rom_addr
//   if_valid        : if_instr/if_pc hold a real fetched instruction
//   if_instr        : fetched instruction word (registered)
//   if_pc           : address if_instr was fetched from (registered)
//   active          : high until the CPU has halted
//
// Modports:
//   master : the fetch unit (drives rom_addr and the if_* results)
//   slave  : the surrounding pipeline / ROM / environment
// ---------------------------------------------------------------------------
interface instr_fetch_if;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic [31:0] rom_addr;
   logic [31:0] rom_data;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        active;

   modport master (
      input  stall,
      input  redirect_valid,
      input  redirect_target,
      input  rom_data,
      output rom_addr,
      output if_valid,
      output if_instr,
      output if_pc,
      output active
   );

   modport slave (
      output stall,
      output redirect_valid,
      output redirect_target,
      output rom_data,
      input  rom_addr,
      input  if_valid,
      input  if_instr,
      input  if_pc,
      input  active
   );
endinterface

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//
// Purpose: MIPS-style instruction fetch stage. Holds the program counter,
// addresses a combinational instruction ROM with it and registers the
// returned word together with its address for decode. Branches/jumps use
// delay-slot semantics: the word at the current pc is still issued on the
// edge that loads the redirect target. A redirect to address 0 is the halt
// request: the delay slot is issued, the stage drains for one edge, then
// parks in HALTED with active deasserted until reset.
//
// Parameters:
//   RESET_VECTOR : first fetch address after reset
//
// Ports:
//   clk   : single clock, all state updates on its rising edge
//   reset : asynchronous, active-high reset
//   bus   : instr_fetch_if.master (stall, redirect, ROM and fetch results)
// ---------------------------------------------------------------------------
module instr_fetch #(
   parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
   input  logic          clk,
   input  logic          reset,
   instr_fetch_if.master bus
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t      state_reg;
   logic [31:0] pc_reg;
   logic [31:0] if_instr_reg;
   logic [31:0] if_pc_reg;
   logic        if_valid_reg;
   logic        active_reg;

   // Redirect seen while stalled, replayed on the first non-stalled edge.
   logic        pending_valid_reg;
   logic [31:0] pending_target_reg;

   logic [31:0] live_target;
   logic        apply_redirect;
   logic [31:0] apply_target;
   logic [31:0] pc_plus4;

   // -----------------------------------------------------------------------
   // Redirect selection
   // -----------------------------------------------------------------------
   always_comb begin
      // Instructions are word aligned; the low address bits are discarded.
      live_target    = {bus.redirect_target[31:2], 2'b00};
      // A live redirect is newer than anything latched during a stall,
      // so it wins when both are present.
      apply_redirect = bus.redirect_valid | pending_valid_reg;
      apply_target   = bus.redirect_valid ? live_target : pending_target_reg;
      // Natural 32-bit wrap: 32'hFFFFFFFC + 4 = 0.
      pc_plus4       = pc_reg + 32'd4;
   end

   // -----------------------------------------------------------------------
   // Outputs
   // -----------------------------------------------------------------------
   assign bus.rom_addr = pc_reg;
   assign bus.if_valid = if_valid_reg;
   assign bus.if_instr = if_instr_reg;
   assign bus.if_pc    = if_pc_reg;
   assign bus.active   = active_reg;

   // -----------------------------------------------------------------------
   // Fetch state machine
   // -----------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg          <= RUN;
         pc_reg             <= RESET_VECTOR;
         if_instr_reg       <= 32'd0;
         if_pc_reg          <= 32'd0;
         if_valid_reg       <= 1'b0;
         active_reg         <= 1'b1;
         pending_valid_reg  <= 1'b0;
         pending_target_reg <= 32'd0;
      end else begin
         case (state_reg)
            RUN: begin
               if (bus.stall) begin
                  // Pipeline frozen; only remember a redirect so it is not lost.
                  if (bus.redirect_valid) begin
                     pending_valid_reg  <= 1'b1;
                     pending_target_reg <= live_target;
                  end
               end else begin
                  // Issue the word at pc (this is the delay slot when a
                  // redirect is applied on the same edge).
                  if_instr_reg <= bus.rom_data;
                  if_pc_reg    <= pc_reg;
                  if_valid_reg <= 1'b1;
                  if (apply_redirect) begin
                     pc_reg            <= apply_target;
                     pending_valid_reg <= 1'b0;
                     // Jump to address 0 is the halt request.
                     if (apply_target == 32'd0) begin
                        state_reg <= DRAIN;
                     end
                  end else begin
                     pc_reg <= pc_plus4;
                  end
               end
            end

            DRAIN: begin
               // pc is held; nothing new is issued.
               if (!bus.stall) begin
                  if_valid_reg <= 1'b0;
                  state_reg    <= HALTED;
               end
            end

            HALTED: begin
               // Stall and redirects are ignored; only reset leaves here.
               // active falls on the first edge spent in HALTED.
               if_valid_reg <= 1'b0;
               active_reg   <= 1'b0;
            end

            default: begin
               state_reg    <= HALTED;
               if_valid_reg <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
//
// Directed bench for instr_fetch. The ROM is a combinational function of
// rom_addr so every expected instruction word follows from its address.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_instr_fetch;

   logic clk;
   logic reset;

   instr_fetch_if bus();

   instr_fetch #(.RESET_VECTOR(32'hBFC00000)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   int n_checks = 0;
   int n_fail   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ROM contents: a distinct word per address.
   function automatic logic [31:0] rom_word(input logic [31:0] a);
      return a ^ 32'h5A5A_3C3C;
   endfunction

   assign bus.rom_data = rom_word(bus.rom_addr);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance one edge and sample 1ns after it.
   task automatic step();
      @(posedge clk);
      #1;
      $display("[%0t] state: if_valid=%0b if_pc=0x%08h if_instr=0x%08h rom_addr=0x%08h active=%0b",
               $time, bus.if_valid, bus.if_pc, bus.if_instr, bus.rom_addr, bus.active);
   endtask

   task automatic check_issue(input string tag, input logic [31:0] pc);
      check({tag, ".valid"}, 32'(bus.if_valid), 32'd1);
      check({tag, ".pc"},    bus.if_pc, pc);
      check({tag, ".instr"}, bus.if_instr, rom_word(pc));
   endtask

   initial begin
      reset               = 1'b1;
      bus.stall           = 1'b0;
      bus.redirect_valid  = 1'b0;
      bus.redirect_target = 32'd0;

      // Reset state
      #2;
      check("rst.valid",    32'(bus.if_valid), 32'd0);
      check("rst.instr",    bus.if_instr, 32'd0);
      check("rst.pc",       bus.if_pc, 32'd0);
      check("rst.active",   32'(bus.active), 32'd1);
      check("rst.rom_addr", bus.rom_addr, 32'hBFC00000);
      step();
      step();
      reset = 1'b0;

      // Sequential fetch from the reset vector
      check("seq.addr0", bus.rom_addr, 32'hBFC00000);
      step(); check_issue("seq0", 32'hBFC00000);
      step(); check_issue("seq1", 32'hBFC00004);
      step(); check_issue("seq2", 32'hBFC00008);
      check("seq.addr3", bus.rom_addr, 32'hBFC0000C);

      // Re-reset mid-cycle, then redirect while pc = BFC00004
      #3 reset = 1'b1;
      #1 check("rerst.addr", bus.rom_addr, 32'hBFC00000);
      reset = 1'b0;
      step(); check_issue("rr0", 32'hBFC00000);
      bus.redirect_valid  = 1'b1;
      bus.redirect_target = 32'hBFC00100;
      step(); check_issue("br.slot", 32'hBFC00004);
      check("br.addr", bus.rom_addr, 32'hBFC00100);
      bus.redirect_valid = 1'b0;
      step(); check_issue("br.tgt", 32'hBFC00100);

      // Stall 3 cycles with a redirect pulse inside the stall
      bus.stall = 1'b1;
      step(); check_issue("st1", 32'hBFC00100);
      bus.redirect_valid  = 1'b1;
      bus.redirect_target = 32'hBFC00200;
      step(); check_issue("st2", 32'hBFC00100);
      bus.redirect_valid = 1'b0;
      step(); check_issue("st3", 32'hBFC00100);
      check("st.addr", bus.rom_addr, 32'hBFC00104);
      bus.stall = 1'b0;
      step(); check_issue("st.slot", 32'hBFC00104);
      check("st.pend_addr", bus.rom_addr, 32'hBFC00200);
      step(); check_issue("st.tgt", 32'hBFC00200);

      // Misaligned target is forced to a word address
      bus.redirect_valid  = 1'b1;
      bus.redirect_target = 32'hBFC00103;
      step(); check_issue("mis.slot", 32'hBFC00204);
      check("mis.addr", bus.rom_addr, 32'hBFC00100);
      bus.redirect_valid = 1'b0;
      step(); check_issue("mis.tgt", 32'hBFC00100);

      // Live redirect beats a pending one, and the pending one is dropped
      bus.stall           = 1'b1;
      bus.redirect_valid  = 1'b1;
      bus.redirect_target = 32'hBFC00300;
      step();
      bus.stall           = 1'b0;
      bus.redirect_target = 32'hBFC00400;
      step(); check_issue("pri.slot", 32'hBFC00104);
      check("pri.addr", bus.rom_addr, 32'hBFC00400);
      bus.redirect_valid = 1'b0;
      step(); check_issue("pri.tgt", 32'hBFC00400);
      check("pri.clear", bus.rom_addr, 32'hBFC00404);

      // PC wraps from FFFFFFFC to 0 without halting
      bus.redirect_valid  = 1'b1;
      bus.redirect_target = 32'hFFFFFFFC;
      step(); check("wrap.addr0", bus.rom_addr, 32'hFFFFFFFC);
      bus.redirect_valid = 1'b0;
      step(); check_issue("wrap.top", 32'hFFFFFFFC);
      check("wrap.addr1", bus.rom_addr, 32'h00000000);
      step(); check_issue("wrap.zero", 32'h00000000);
      check("wrap.active", 32'(bus.active), 32'd1);

      // Halt: redirect to 0 from pc = 4
      bus.redirect_valid  = 1'b1;
      bus.redirect_target = 32'h00000000;
      step(); check_issue("halt.slot", 32'h00000004);
      check("halt.active0", 32'(bus.active), 32'd1);
      bus.redirect_target = 32'hBFC00000;
      step();
      check("drain.valid",  32'(bus.if_valid), 32'd0);
      check("drain.active", 32'(bus.active), 32'd1);
      check("drain.addr",   bus.rom_addr, 32'h00000000);
      step();
      check("halt.valid",  32'(bus.if_valid), 32'd0);
      check("halt.active", 32'(bus.active), 32'd0);
      for (int i = 0; i < 3; i++) begin
         bus.stall = (i == 1);
         step();
         check("halted.addr",   bus.rom_addr, 32'h00000000);
         check("halted.active", 32'(bus.active), 32'd0);
         check("halted.valid",  32'(bus.if_valid), 32'd0);
         check("halted.pc",     bus.if_pc, 32'h00000004);
      end
      bus.redirect_valid = 1'b0;
      bus.stall          = 1'b0;

      // Asynchronous reset while HALTED, observed before the next edge
      #3 reset = 1'b1;
      #1;
      check("arst.active", 32'(bus.active), 32'd1);
      check("arst.addr",   bus.rom_addr, 32'hBFC00000);
      check("arst.valid",  32'(bus.if_valid), 32'd0);
      check("arst.pc",     bus.if_pc, 32'd0);
      reset = 1'b0;
      step(); check_issue("arst.fetch", 32'hBFC00000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'hBFC00000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port stall, input, 1 bit: downstream cannot accept; hold PC and outputs.
REQ-005 SHALL have port redirect_valid, input, 1 bit: taken branch/jump resolved in decode.
REQ-006 SHALL have port redirect_target, input, 32 bits: byte address of the branch/jump destination.
REQ-007 SHALL have port rom_addr, output, 32 bits: byte address driven to the instruction ROM.
REQ-008 SHALL have port rom_data, input, 32 bits: instruction word returned combinationally by the ROM for rom_addr.
REQ-009 SHALL have port if_valid, output, 1 bit: if_instr/if_pc hold a real fetched instruction.
REQ-010 SHALL have port if_instr, output, 32 bits: fetched instruction word, registered.
REQ-011 SHALL have port if_pc, output, 32 bits: address the if_instr word was fetched from.
REQ-012 SHALL have port active, output, 1 bit: high until the CPU has halted.

Function
REQ-013 SHALL hold an internal 32-bit pc and drive rom_addr = pc combinationally, with the same-cycle rom_data being the word at pc.
REQ-014 SHALL, on each non-stalled edge in RUN, capture if_instr<=rom_data, if_pc<=pc and if_valid<=1, giving exactly one cycle of fetch latency.
REQ-015 SHALL, on a non-stalled edge without redirect, update pc<=pc+4, with 32-bit wrap (32'hFFFFFFFC+4=0).
REQ-016 SHALL implement MIPS delay-slot semantics: on a redirect, the instruction at the current pc (the delay slot) is still issued and pc<=target on that edge.
REQ-017 SHALL force redirect_target[1:0] to 2'b00 before use.
REQ-018 SHALL, when stall=1, keep pc, if_instr, if_pc, if_valid and state unchanged.
REQ-019 SHALL latch a redirect arriving while stall=1 into a pending register (valid flag plus target).
REQ-020 SHALL apply the pending redirect on the first non-stalled edge.
REQ-021 SHALL give a live redirect_valid priority over a pending one on the same non-stalled edge, and SHALL clear the pending flag whenever any redirect is applied.
REQ-022 SHALL implement a state machine with states RUN, DRAIN and HALTED.
REQ-023 SHALL move RUN->DRAIN when a redirect with target 32'h00000000 is applied, the delay slot being issued on that same edge.
REQ-024 SHALL move DRAIN->HALTED on the next non-stalled edge; in DRAIN, if_valid<=0 and pc SHALL be held.
REQ-025 SHALL in HALTED drive active=0 and if_valid=0, ignore redirect_valid and stall, and leave HALTED only on reset.
REQ-026 SHALL drive active=1 in RUN and DRAIN.

Reset
REQ-027 SHALL, while reset=1, set asynchronously: pc=RESET_VECTOR, if_valid=0, if_instr=0, if_pc=0, pending flag=0, state=RUN, active=1.
REQ-028 SHALL, after reset deasserts, make its first fetch at RESET_VECTOR and present it with if_valid=1 one edge later.
REQ-029 SHALL, on reset asserted mid-stall, mid-redirect or in HALTED, fully override all of these with the REQ-027 values.

Verification
REQ-030 SHALL be verified by a bench covering these scenarios:
- Reset release, no stall, ROM words W0..W2 at BFC00000..BFC00008 -> if_pc 0xBFC00000/4/8 on consecutive edges with if_instr W0,W1,W2 and if_valid=1 throughout.
- Redirect to 0xBFC00100 while pc=0xBFC00004 -> next issued pcs 0xBFC00004 (delay slot), then 0xBFC00100.
- stall=1 for 3 cycles with redirect_valid pulsed to 0xBFC00200 during the stall -> outputs frozen; after stall drops, delay slot issued, then 0xBFC00200.
- Redirect to 0x00000000 -> delay slot issued, if_valid=0 next cycle, active=0 the cycle after, and no further change despite redirects to 0xBFC00000.
- Redirect target 0xBFC00103 -> fetch at 0xBFC00100.
- Reset asserted asynchronously mid-cycle while HALTED -> active=1 and rom_addr=0xBFC00000 immediately, before the next clock edge.
